// File: rtl/eh2_dccm_mport_pkg.sv
// Shared types and helpers for the multi-channel, multi-bank DCCM front-end.
//   bank_state_t : per-bank sequencer state (IDLE / RMW_WR)
//   BO/BB/ROWS   : address-split constants for the default geometry
//   byte_merge   : bytewise merge used by the read-modify-write path
//   rr_pick      : round-robin pick from a request vector and pointer
//   rr_next      : pointer value after a grant
package eh2_dccm_mport_pkg;

  typedef enum logic {IDLE = 1'b0, RMW_WR = 1'b1} bank_state_t;

  // Widest configuration the helpers handle; callers size-cast in and out.
  localparam int MAX_CH = 4;
  localparam int MAX_DW = 128;
  localparam int MAX_BE = MAX_DW / 8;

  // Default geometry (4 banks of 32-bit words over a 16-bit byte address).
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 32;
  localparam int BO   = $clog2(DEF_DATA_W / 8);
  localparam int BB   = $clog2(DEF_NUM_BANKS);
  localparam int ROWS = 2 ** (DEF_ADDR_W - BO - BB);

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0] old_w,
                                                   input logic [MAX_DW-1:0] new_w,
                                                   input logic [MAX_BE-1:0] be);
    logic [MAX_DW-1:0] r;
    for (int i = 0; i < MAX_BE; i++)
      r[i*8 +: 8] = be[i] ? new_w[i*8 +: 8] : old_w[i*8 +: 8];
    return r;
  endfunction

  // Returns {found, idx}. Scans from the highest offset down so the
  // channel closest to ptr is the one left standing.
  function automatic logic [2:0] rr_pick(input logic [MAX_CH-1:0] req,
                                         input logic [1:0]        ptr,
                                         input int                nch);
    logic [2:0] r;
    int idx;
    r = '0;
    for (int k = MAX_CH - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % nch;
      if (k < nch && req[idx]) r = {1'b1, 2'(idx)};
    end
    return r;
  endfunction

  function automatic logic [1:0] rr_next(input logic [1:0] idx, input int nch);
    return 2'((int'(idx) + 1) % nch);
  endfunction

endpackage

// File: rtl/eh2_dccm_bank.sv
// Single-ported DCCM bank: ROWS x DATA_W array, registered read data.
//   clk   : core clock
//   re    : read strobe, rdata valid the following cycle
//   we    : write strobe (never asserted together with re)
//   row   : row address
//   wdata : write word
//   rdata : word read on the last re cycle (held otherwise)
module eh2_dccm_bank
  import eh2_dccm_mport_pkg::*;
#(
  parameter int ROWS   = 4096,
  parameter int DATA_W = 32
) (
  input  logic                    clk,
  input  logic                    re,
  input  logic                    we,
  input  logic [$clog2(ROWS)-1:0] row,
  input  logic [DATA_W-1:0]       wdata,
  output logic [DATA_W-1:0]       rdata
);

  logic [DATA_W-1:0] mem [ROWS];
  logic [DATA_W-1:0] rdata_q, rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[row];
  end

  always_ff @(posedge clk) begin
    if (we) mem[row] <= wdata;
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/eh2_dccm_mport.sv
// Multi-channel, multi-bank DCCM front-end. NUM_CH requesters share
// NUM_BANKS single-ported banks; each bank arbitrates round-robin and runs a
// two-cycle read-modify-write for partial byte-enable writes.
//   clk, rst   : core clock, synchronous active-high reset
//   req_*      : per-channel request (valid/ready handshake, flat packed)
//   rsp_valid  : read data valid, exactly one cycle after a read grant
//   rsp_rdata  : read data, zero when rsp_valid is low
//   stall_cnt  : saturating count of cycles with any valid & !ready
module eh2_dccm_mport
  import eh2_dccm_mport_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_CH-1:0]          req_valid,
  output logic [NUM_CH-1:0]          req_ready,
  input  logic [NUM_CH-1:0]          req_we,
  input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
  input  logic [NUM_CH*DATA_W-1:0]   req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0] req_be,
  output logic [NUM_CH-1:0]          rsp_valid,
  output logic [NUM_CH*DATA_W-1:0]   rsp_rdata,
  output logic [15:0]                stall_cnt
);

  localparam int NB    = DATA_W / 8;
  localparam int LBO   = $clog2(NB);
  localparam int LBB   = $clog2(NUM_BANKS);
  localparam int RW    = ADDR_W - LBO - LBB;
  localparam int LROWS = 2 ** RW;
  localparam int BW    = (LBB > 0) ? LBB : 1;

  logic [NUM_CH-1:0][BW-1:0]        ch_bank;
  logic [NUM_CH-1:0][RW-1:0]        ch_row;
  logic [NUM_BANKS-1:0][NUM_CH-1:0] gnt;
  logic [NUM_BANKS-1:0][DATA_W-1:0] bank_rdata;

  // ---------------- address decode ----------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_dec
    assign ch_row[c] = req_addr[c*ADDR_W+LBO+LBB +: RW];
    if (LBB > 0) begin : g_bsel
      assign ch_bank[c] = req_addr[c*ADDR_W+LBO +: LBB];
    end else begin : g_bzero
      assign ch_bank[c] = '0;
    end
  end

  // Byte offset within the word plays no part in the access.
  if (LBO > 0) begin : g_lsb
    logic [NUM_CH*LBO-1:0] unused_lsb;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_l
      assign unused_lsb[c*LBO +: LBO] = req_addr[c*ADDR_W +: LBO];
    end
  end

  // ---------------- per-bank arbiter + RMW sequencer ----------------
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    bank_state_t       state_q, state_d;
    logic [1:0]        rr_q, rr_d;
    logic [RW-1:0]     rmw_row_q, rmw_row_d;
    logic [DATA_W-1:0] rmw_wd_q, rmw_wd_d;
    logic [NB-1:0]     rmw_be_q, rmw_be_d;
    logic [MAX_CH-1:0] breq;
    logic [2:0]        pick;
    logic [NUM_CH-1:0] gnt_b;
    logic              sel_we;
    logic [RW-1:0]     sel_row;
    logic [DATA_W-1:0] sel_wd;
    logic [NB-1:0]     sel_be;
    logic              mem_re, mem_we;
    logic [RW-1:0]     mem_row;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] bank_rdata_b;

    always_comb begin
      breq = '0;
      for (int c = 0; c < NUM_CH; c++)
        breq[c] = req_valid[c] && (ch_bank[c] == BW'(b));
      pick = rr_pick(breq, rr_q, NUM_CH);

      gnt_b   = '0;
      sel_we  = 1'b0;
      sel_row = '0;
      sel_wd  = '0;
      sel_be  = '0;
      // No grants while in reset or while the merge write owns the array.
      if (!rst && state_q == IDLE && pick[2]) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (pick[1:0] == 2'(c)) begin
            gnt_b[c] = 1'b1;
            sel_we   = req_we[c];
            sel_row  = ch_row[c];
            sel_wd   = req_wdata[c*DATA_W +: DATA_W];
            sel_be   = req_be[c*NB +: NB];
          end
        end
      end

      mem_re    = 1'b0;
      mem_we    = 1'b0;
      mem_row   = sel_row;
      mem_wd    = sel_wd;
      state_d   = state_q;
      rr_d      = rr_q;
      rmw_row_d = rmw_row_q;
      rmw_wd_d  = rmw_wd_q;
      rmw_be_d  = rmw_be_q;

      if (state_q == RMW_WR) begin
        // Old row arrived in the bank's read register; reset drops the merge.
        mem_we  = !rst;
        mem_row = rmw_row_q;
        mem_wd  = DATA_W'(byte_merge(MAX_DW'(bank_rdata_b), MAX_DW'(rmw_wd_q),
                                     MAX_BE'(rmw_be_q)));
        state_d = IDLE;
      end else if (|gnt_b) begin
        rr_d = rr_next(pick[1:0], NUM_CH);
        if (!sel_we) begin
          mem_re = 1'b1;
        end else if (&sel_be) begin
          mem_we = 1'b1;
        end else if (|sel_be) begin
          mem_re    = 1'b1;
          state_d   = RMW_WR;
          rmw_row_d = sel_row;
          rmw_wd_d  = sel_wd;
          rmw_be_d  = sel_be;
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        state_q   <= IDLE;
        rr_q      <= '0;
        rmw_row_q <= '0;
        rmw_wd_q  <= '0;
        rmw_be_q  <= '0;
      end else begin
        state_q   <= state_d;
        rr_q      <= rr_d;
        rmw_row_q <= rmw_row_d;
        rmw_wd_q  <= rmw_wd_d;
        rmw_be_q  <= rmw_be_d;
      end
    end

    assign gnt[b]        = gnt_b;
    assign bank_rdata[b] = bank_rdata_b;

    eh2_dccm_bank #(.ROWS(LROWS), .DATA_W(DATA_W)) u_bank (
      .clk   (clk),
      .re    (mem_re),
      .we    (mem_we),
      .row   (mem_row),
      .wdata (mem_wd),
      .rdata (bank_rdata_b)
    );
  end

  // ---------------- ready, response routing, stall counter ----------------
  logic [NUM_CH-1:0]         rsp_pend_q, rsp_pend_d;
  logic [NUM_CH-1:0][BW-1:0] rsp_bank_q, rsp_bank_d;
  logic [15:0]               stall_q, stall_d;

  always_comb begin
    req_ready = '0;
    for (int b = 0; b < NUM_BANKS; b++) req_ready = req_ready | gnt[b];
  end

  always_comb begin
    rsp_pend_d = req_ready & ~req_we;
    rsp_bank_d = ch_bank;
    stall_d    = stall_q;
    if (|(req_valid & ~req_ready) && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;

    // Read data comes straight off the bank that served the read last cycle.
    rsp_rdata = '0;
    for (int c = 0; c < NUM_CH; c++)
      for (int b = 0; b < NUM_BANKS; b++)
        if (rsp_pend_q[c] && rsp_bank_q[c] == BW'(b))
          rsp_rdata[c*DATA_W +: DATA_W] = bank_rdata[b];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q <= '0;
      rsp_bank_q <= '0;
      stall_q    <= '0;
    end else begin
      rsp_pend_q <= rsp_pend_d;
      rsp_bank_q <= rsp_bank_d;
      stall_q    <= stall_d;
    end
  end

  assign rsp_valid = rsp_pend_q;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_eh2_dccm_mport.sv
module tb_eh2_dccm_mport;
  localparam int N   = 3;
  localparam int NBK = 4;
  localparam int AW  = 16;
  localparam int DW  = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]    v, we;
  logic [AW-1:0]   ad [N];
  logic [DW-1:0]   wd [N];
  logic [3:0]      be [N];
  logic [N*AW-1:0] ad_p;
  logic [N*DW-1:0] wd_p;
  logic [N*4-1:0]  be_p;
  logic [N-1:0]    rdy, rv;
  logic [N*DW-1:0] rdat;
  logic [15:0]     stall;

  always_comb begin
    ad_p = '0;
    wd_p = '0;
    be_p = '0;
    for (int c = 0; c < N; c++) begin
      ad_p[c*AW +: AW] = ad[c];
      wd_p[c*DW +: DW] = wd[c];
      be_p[c*4 +: 4]   = be[c];
    end
  end

  eh2_dccm_mport #(.NUM_CH(N), .NUM_BANKS(NBK), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(v), .req_ready(rdy), .req_we(we), .req_addr(ad_p),
    .req_wdata(wd_p), .req_be(be_p),
    .rsp_valid(rv), .rsp_rdata(rdat), .stall_cnt(stall)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] mem_m [64];          // word index = addr[7:2]
  int          rr_m   [NBK];
  bit          busy_m [NBK];
  int          pw_m   [NBK];
  logic [31:0] pd_m   [NBK];
  logic [3:0]  pb_m   [NBK];
  logic [N-1:0] exp_rdy, exp_rv;
  logic [31:0] exp_rd [N];
  int          exp_stall;

  int n_chk = 0;
  int n_err = 0;

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Who gets granted this cycle, from the round-robin rule.
  task automatic model_comb();
    exp_rdy = '0;
    for (int b = 0; b < NBK; b++) begin
      bit done;
      done = 0;
      if (!rst && !busy_m[b]) begin
        for (int k = 0; k < N; k++) begin
          int c;
          c = (rr_m[b] + k) % N;
          if (!done && v[c] && int'(ad[c][3:2]) == b) begin
            exp_rdy[c] = 1'b1;
            done = 1;
          end
        end
      end
    end
  endtask

  // State effect of the clock edge.
  task automatic model_seq();
    if (rst) begin
      for (int b = 0; b < NBK; b++) begin rr_m[b] = 0; busy_m[b] = 0; end
      exp_rv = '0;
      for (int c = 0; c < N; c++) exp_rd[c] = '0;
      exp_stall = 0;
    end else begin
      if (|(v & ~exp_rdy) && exp_stall < 65535) exp_stall++;
      for (int c = 0; c < N; c++) begin
        exp_rv[c] = exp_rdy[c] && !we[c];
        exp_rd[c] = exp_rv[c] ? mem_m[ad[c][7:2]] : 32'h0;
      end
      for (int b = 0; b < NBK; b++)
        if (busy_m[b]) begin
          mem_m[pw_m[b]] = merge(mem_m[pw_m[b]], pd_m[b], pb_m[b]);
          busy_m[b] = 0;
        end
      for (int c = 0; c < N; c++)
        if (exp_rdy[c]) begin
          int b;
          b = int'(ad[c][3:2]);
          rr_m[b] = (c + 1) % N;
          if (we[c]) begin
            if (be[c] == 4'hF) mem_m[ad[c][7:2]] = wd[c];
            else if (be[c] != 4'h0) begin
              busy_m[b] = 1;
              pw_m[b] = int'(ad[c][7:2]);
              pd_m[b] = wd[c];
              pb_m[b] = be[c];
            end
          end
        end
    end
  endtask

  task automatic compare();
    for (int c = 0; c < N; c++) begin
      chk($sformatf("ready[%0d]", c), rdy[c], exp_rdy[c]);
      chk($sformatf("rsp_valid[%0d]", c), rv[c], exp_rv[c]);
      chk($sformatf("rsp_rdata[%0d]", c), rdat[c*DW +: DW], exp_rd[c]);
    end
    chk("stall_cnt", stall, 64'(exp_stall));
  endtask

  // ---------------- cycle helpers ----------------
  task automatic half();
    model_comb();
    @(negedge clk);
    compare();
  endtask

  task automatic fin();
    @(posedge clk);
    model_seq();
    #1;
  endtask

  task automatic cycle();
    half();
    fin();
  endtask

  task automatic idle_all();
    v = '0;
    we = '0;
    for (int c = 0; c < N; c++) begin ad[c] = '0; wd[c] = '0; be[c] = '0; end
  endtask

  task automatic set_req(input int c, input bit w, input logic [15:0] a,
                         input logic [31:0] d, input logic [3:0] b);
    v[c] = 1'b1; we[c] = w; ad[c] = a; wd[c] = d; be[c] = b;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    for (int b = 0; b < NBK; b++) begin
      rr_m[b] = 0; busy_m[b] = 0; pw_m[b] = 0; pd_m[b] = '0; pb_m[b] = '0;
    end
    exp_rdy = '0; exp_rv = '0; exp_stall = 0;
    for (int c = 0; c < N; c++) exp_rd[c] = '0;

    @(posedge clk); #1;
    half();
    chk("reset_ready", rdy, 3'b000);
    chk("reset_stall", stall, 16'h0);
    fin();
    rst = 1'b0;

    // preload: three banks written in parallel, then 0x10
    set_req(0, 1, 16'h0000, 32'hCAFE0000, 4'hF);
    set_req(1, 1, 16'h0004, 32'hCAFE0004, 4'hF);
    set_req(2, 1, 16'h0008, 32'hCAFE0008, 4'hF);
    cycle(); idle_all();
    set_req(0, 1, 16'h0010, 32'h11223344, 4'hF);
    cycle(); idle_all();

    // 1: parallel, no conflict
    do_reset();
    set_req(0, 0, 16'h0000, 0, 0);
    set_req(1, 0, 16'h0004, 0, 0);
    half(); chk("t1_ready", rdy, 3'b011); fin(); idle_all();
    half();
    chk("t1_rv", rv, 3'b011);
    chk("t1_d0", rdat[31:0], 32'hCAFE0000);
    chk("t1_d1", rdat[63:32], 32'hCAFE0004);
    chk("t1_stall", stall, 16'd0);
    fin();

    // 2: round-robin conflict on bank2
    do_reset();
    set_req(0, 0, 16'h0008, 0, 0);
    set_req(1, 0, 16'h0008, 0, 0);
    half(); chk("t2_r0", rdy, 3'b001); fin(); v[0] = 1'b0;
    half(); chk("t2_r1", rdy, 3'b010); chk("t2_rv1", rv, 3'b001);
    chk("t2_d0", rdat[31:0], 32'hCAFE0008); fin();
    set_req(0, 0, 16'h0008, 0, 0);
    set_req(1, 0, 16'h0008, 0, 0);
    half(); chk("t2_r2", rdy, 3'b001); chk("t2_stall", stall, 16'd1);
    chk("t2_rv2", rv, 3'b010); chk("t2_d1", rdat[63:32], 32'hCAFE0008); fin();
    v[0] = 1'b0;
    half(); chk("t2_r3", rdy, 3'b010); fin(); idle_all();
    cycle();

    // 3: partial write then read of the same word
    do_reset();
    set_req(0, 1, 16'h0010, 32'h0000AA00, 4'b0010);
    set_req(1, 0, 16'h0010, 0, 0);
    half(); chk("t3_r0", rdy, 3'b001); fin(); v[0] = 1'b0;
    half(); chk("t3_busy", rdy, 3'b000); fin();
    half(); chk("t3_r2", rdy, 3'b010); fin(); idle_all();
    half(); chk("t3_rv", rv, 3'b010); chk("t3_data", rdat[63:32], 32'h1122AA44);
    chk("t3_stall", stall, 16'd2); fin();

    // 4: full write, then be=0 write, then read back
    set_req(0, 1, 16'h0020, 32'hDEADBEEF, 4'hF);
    half(); chk("t4_r0", rdy, 3'b001); fin();
    set_req(0, 1, 16'h0020, 32'hFFFFFFFF, 4'h0);
    half(); chk("t4_r1", rdy, 3'b001); chk("t4_rv0", rv, 3'b000); fin(); idle_all();
    half(); chk("t4_rv1", rv, 3'b000); fin();
    set_req(0, 0, 16'h0020, 0, 0);
    cycle(); idle_all();
    half(); chk("t4_rv", rv, 3'b001); chk("t4_data", rdat[31:0], 32'hDEADBEEF); fin();

    // 5: reset lands in the merge cycle
    set_req(0, 1, 16'h0010, 32'h11223344, 4'hF);
    cycle(); idle_all();
    set_req(0, 1, 16'h0010, 32'h0000AA00, 4'b0010);
    half(); chk("t5_r0", rdy, 3'b001); fin(); idle_all();
    rst = 1'b1;
    half(); chk("t5_rst_ready", rdy, 3'b000); fin();
    rst = 1'b0;
    half(); chk("t5_rv", rv, 3'b000); chk("t5_stall", stall, 16'd0); fin();
    set_req(1, 0, 16'h0010, 0, 0);
    half(); chk("t5_r1", rdy, 3'b010); fin(); idle_all();
    half(); chk("t5_rv1", rv, 3'b010); chk("t5_data", rdat[63:32], 32'h11223344); fin();

    // 6: three-channel fairness on bank0
    do_reset();
    set_req(0, 0, 16'h0000, 0, 0);
    set_req(1, 0, 16'h0010, 0, 0);
    set_req(2, 0, 16'h0020, 0, 0);
    for (int k = 0; k < 6; k++) begin
      logic [2:0] e;
      half();
      e = 3'b001 << (k % 3);
      chk($sformatf("t6_ready%0d", k), rdy, e);
      if (k > 0) begin
        e = 3'b001 << ((k - 1) % 3);
        chk($sformatf("t6_rv%0d", k), rv, e);
      end
      fin();
    end
    idle_all();
    cycle();

    // random traffic over a preloaded 16-word pool
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_req(0, 1, 16'(i * 4), $urandom, 4'hF);
      cycle();
      idle_all();
    end
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < N; c++) begin
        if (!v[c] || exp_rdy[c]) begin
          if ($urandom_range(0, 9) < 7) begin
            logic [3:0] b;
            int sel;
            sel = $urandom_range(0, 3);
            b = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            set_req(c, ($urandom_range(0, 9) < 4),
                    16'($urandom_range(0, 15) * 4 + $urandom_range(0, 3)),
                    $urandom, b);
          end else begin
            v[c] = 1'b0;
          end
        end
      end
      rst = ($urandom_range(0, 199) == 0);
      cycle();
    end
    rst = 1'b0;
    idle_all();
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/eh2_dccm_mport.md
Name: eh2_dccm_mport

Overview:
Parametrised multi-channel, multi-bank DCCM front-end. It generalises the fixed lo/hi DCCM pair to NUM_CH request channels over NUM_BANKS single-ported banks. Each bank has a per-bank round-robin arbiter and a read-modify-write engine for byte-masked writes. It sits between the LSU/DMA request sources and the DCCM arrays, and provides fixed 1-cycle read latency and a stall statistics counter.

Parameters:
NUM_CH, 2, number of request channels (1..4)
NUM_BANKS, 4, number of banks (power of 2, 1..8)
ADDR_W, 16, byte address width
DATA_W, 32, bank word width (multiple of 8; DATA_W/8 a power of 2)
Derived: BO=log2(DATA_W/8), BB=log2(NUM_BANKS), ROWS=2^(ADDR_W-BO-BB)

Ports:
clk  in  1  core clock
rst  in  1  reset; synchronous, active-high
req_valid  in  NUM_CH  per-channel request valid
req_ready  out  NUM_CH  request accepted this cycle
req_we  in  NUM_CH  1=write, 0=read
req_addr  in  NUM_CH*ADDR_W  byte address, channel c at [c*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CH*DATA_W  write data
req_be  in  NUM_CH*DATA_W/8  byte enables (writes only)
rsp_valid  out  NUM_CH  read data valid
rsp_rdata  out  NUM_CH*DATA_W  read data
stall_cnt  out  16  saturating count of cycles with any valid & !ready

Behaviour:
- Address decode: bank=addr[BO+BB-1:BO], row=addr[ADDR_W-1:BO+BB]; addr[BO-1:0] is ignored.
- Each bank performs at most one array access per cycle.
- Per-bank state: IDLE, RMW_WR.
  - IDLE: grant one of the valid channels targeting this bank.
  - RMW_WR: no grant; perform the merged write; return to IDLE next cycle.
- Arbitration per bank: round-robin starting at rr_ptr[b]. On a grant to channel c, rr_ptr[b] <= (c+1) mod NUM_CH. No grant leaves rr_ptr unchanged.
- req_ready[c] is combinational and equals granted(c).
- Handshake: the requester holds valid and all fields stable until ready. A channel may issue back-to-back requests.
- Read grant: the array is read in the grant cycle. rsp_valid[c]=1 exactly one cycle later, carrying the bank word. rsp_rdata[c]=0 whenever rsp_valid[c]=0.
- Write grant, be all ones: the array is written in the grant cycle. No response.
- Write grant, be==0: accepted, array untouched, no response, bank stays IDLE.
- Write grant, partial be: the row is read in the grant cycle, and row/wdata/be are latched. The bank goes to RMW_WR. Next cycle it writes merge(old,wdata,be) bytewise, then returns to IDLE. The bank is unavailable for that one cycle.
- Ordering: any access to a bank granted after an RMW grant observes the merged data.
- A channel receives at most one grant per cycle. Channels targeting different banks are granted in parallel.
- stall_cnt: increments by 1 per cycle in which any req_valid[c] & !req_ready[c]. It saturates at 0xFFFF.
- Reset (any cycle, including RMW_WR):
  - rr_ptr=0, all banks IDLE, rsp_valid=0, rsp_rdata=0, stall_cnt=0.
  - req_ready=0 while rst=1.
  - A pending RMW merge is dropped; the array keeps its pre-RMW contents.
  - Array contents are not reset.

Decomposition:
- Package eh2_dccm_mport_pkg holds:
  - enum bank_state_t {IDLE, RMW_WR}
  - function byte_merge(old, new, be)
  - localparams BO, BB, ROWS derived via $clog2
  - a function computing the round-robin pick from a request vector and rr_ptr
- Sub-module eh2_dccm_bank: single-port ROWS x DATA_W array with registered read data (1-cycle latency), write enable, and row address. It is instantiated NUM_BANKS times via generate.

Test Plan:
1. Parallel, no conflict: ch0 read 0x0000 (bank0) and ch1 read 0x0004 (bank1) in cycle T -> both ready in T; rsp_valid=2'b11 in T+1 with preloaded words; stall_cnt stays 0.
2. Round-robin conflict: ch0 and ch1 both read 0x0008 (bank2) from T, rr_ptr=0 -> ch0 ready in T, ch1 ready in T+1; stall_cnt=1. Then both request bank2 again at T+2 -> ch0 wins (rr_ptr=0 after ch1's grant).
3. Partial write then read: preload 0x11223344 at 0x0010. In T, ch0 writes be=4'b0010, wdata=0x0000AA00, and ch1 reads 0x0010 -> ch0 ready in T; bank busy in T+1; ch1 ready in T+2; rsp in T+3 with 0x1122AA44; stall_cnt=2.
4. Full write and be=0 write: ch0 writes 0xDEADBEEF with be=4'hF to 0x0020, then writes be=0 with 0xFFFFFFFF -> both accepted with no rsp; a later read of 0x0020 returns 0xDEADBEEF.
5. Reset mid-RMW: repeat scenario 3's write with rst=1 in T+1 -> after reset, rsp_valid=0 and stall_cnt=0; a read of 0x0010 returns 0x11223344.
6. Three-channel fairness (NUM_CH=3): all three channels continuously read bank0 -> grant order 0,1,2,0,1,2; each channel receives exactly one rsp every 3 cycles.
